clk_rst_mgr: RTL and testbench

Parametrised clock/reset manager between the board PLL and the CPU/bus domain. It replaces the AND-gating of the PLL clock with its lock signal. It runs on the PLL output clock and qualifies PLL lock with a synchroniser plus a stability counter. It then releases a sequenced synchronous system reset and drives per-channel clock enables: programmable divide ratio per channel, plus a single-step debug mode so the CPU can be stepped from a board button.

---
 rtl/clk_rst_mgr_pkg.sv | 24 ++
 rtl/clk_rst_mgr_if.sv | 29 ++
 rtl/clk_en_div.sv | 53 +++++
 rtl/clk_rst_mgr.sv | 128 ++++++++++++
 tb/tb_clk_rst_mgr.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/clk_rst_mgr_pkg.sv
// Shared constants for the PLL clock/reset manager: FSM encodings, default parameters.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package clk_rst_mgr_pkg;

    typedef logic [1:0] state_t;

    // Encoding 2'd3 is never produced and decodes as WAIT_LOCK.
    localparam state_t ST_WAIT_LOCK = 2'd0;
    localparam state_t ST_HOLD      = 2'd1;
    localparam state_t ST_RUN       = 2'd2;

    localparam int DEF_NUM_CH      = 2;
    localparam int DEF_DIV_W       = 8;
    localparam int DEF_LOCK_CYCLES = 16;
    localparam int DEF_RST_HOLD    = 8;
    localparam int DEF_SYNC_STAGES = 2;

    // Bits needed to hold the values 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/clk_rst_mgr_if.sv
// Board-side signal bundle of the clock/reset manager (lock, divide config, step, outputs).
// Latency: n/a (wires only).
// Backpressure: none; all signals are levels or single-cycle pulses.
// master: board/CPU side driving lock, config and step inputs.
// slave : clk_rst_mgr, driving rst_out_n, clk_en, state, lock_lost.
interface clk_rst_mgr_if #(
    parameter int NUM_CH = 2,
    parameter int DIV_W  = 8
);
    logic                    pll_locked;
    logic [NUM_CH*DIV_W-1:0] div_cfg;
    logic                    cfg_we;
    logic                    step_mode;
    logic                    step_req;
    logic                    rst_out_n;
    logic [NUM_CH-1:0]       clk_en;
    logic [1:0]              state;
    logic                    lock_lost;

    modport master (
        output pll_locked, div_cfg, cfg_we, step_mode, step_req,
        input  rst_out_n, clk_en, state, lock_lost
    );

    modport slave (
        input  pll_locked, div_cfg, cfg_we, step_mode, step_req,
        output rst_out_n, clk_en, state, lock_lost
    );
endinterface

// File: rtl/clk_en_div.sv
// One clock-enable channel: divide register, wrap counter and registered enable pulse.
// Latency: enable registered; first pulse div+1 cycles after active_i rises, step pulse 1 cycle after step_i.
// Backpressure: none; load_i/hold_i/inactive force the counter to 0 and suppress the pulse.
// Ports: clk, rst_n; load_i/cfg_i load the ratio; active_i = staying in RUN;
//        hold_i = mode change; step_mode_i/step_i = single-step; en_o = enable.
module clk_en_div #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [DIV_W-1:0] cfg_i,
    input  logic             active_i,
    input  logic             hold_i,
    input  logic             step_mode_i,
    input  logic             step_i,
    output logic             en_o
);
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             en_q, en_d;

    always_comb begin
        // The ratio is stored even when the load coincides with lock loss.
        div_d = load_i ? cfg_i : div_q;
        cnt_d = '0;
        en_d  = 1'b0;
        // A load restarts the count and never emits a pulse in its own cycle.
        if (active_i && !load_i && !hold_i) begin
            if (step_mode_i) begin
                en_d = step_i;
            end else if (cnt_q == div_q) begin
                en_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
            cnt_q <= '0;
            en_q  <= 1'b0;
        end else begin
            div_q <= div_d;
            cnt_q <= cnt_d;
            en_q  <= en_d;
        end
    end

    assign en_o = en_q;
endmodule

// File: rtl/clk_rst_mgr.sv
// Qualifies PLL lock, sequences the system reset and drives per-channel clock enables.
// Latency: lock->reset release SYNC_STAGES+LOCK_CYCLES+RST_HOLD edges; lock loss->reset SYNC_STAGES+1.
// Backpressure: none; outputs are registered levels/pulses.
// Ports: clk (PLL clock), rst_n (async, active-low); bus (slave modport): pll_locked,
//        div_cfg, cfg_we, step_mode, step_req in; rst_out_n, clk_en, state, lock_lost out.
module clk_rst_mgr
    import clk_rst_mgr_pkg::*;
#(
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int DIV_W       = DEF_DIV_W,
    parameter int LOCK_CYCLES = DEF_LOCK_CYCLES,
    parameter int RST_HOLD    = DEF_RST_HOLD,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic         clk,
    input  logic         rst_n,
    clk_rst_mgr_if.slave bus
);
    localparam int CNT_W = cnt_width((LOCK_CYCLES > RST_HOLD) ? LOCK_CYCLES : RST_HOLD);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD - 1);

    logic [SYNC_STAGES-1:0] lock_sync_q, mode_sync_q, req_sync_q;
    logic                   locked_s, mode_s, req_s;
    logic                   req_s_d_q, mode_s_d_q, step_pls_q;
    logic                   mode_chg, div_active;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       lcnt_q, lcnt_d;
    logic                   lost_q, lost_d;
    logic                   rst_out_q;
    logic [NUM_CH-1:0]      clk_en_w;

    assign locked_s = lock_sync_q[SYNC_STAGES-1];
    assign mode_s   = mode_sync_q[SYNC_STAGES-1];
    assign req_s    = req_sync_q[SYNC_STAGES-1];
    assign mode_chg = mode_s ^ mode_s_d_q;

    always_comb begin
        state_d = state_q;
        lcnt_d  = lcnt_q;
        lost_d  = lost_q;
        case (state_q)
            ST_HOLD: begin
                if (!locked_s) begin
                    state_d = ST_WAIT_LOCK;
                    lcnt_d  = '0;
                end else if (lcnt_q == HOLD_LAST) begin
                    state_d = ST_RUN;
                    lcnt_d  = '0;
                end else begin
                    lcnt_d = lcnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                lcnt_d = '0;
                if (!locked_s) begin
                    state_d = ST_WAIT_LOCK;
                    lost_d  = 1'b1;
                end
            end
            default: begin
                // WAIT_LOCK, and the unused encoding which falls back here.
                state_d = ST_WAIT_LOCK;
                if (!locked_s) begin
                    lcnt_d = '0;
                end else if (lcnt_q == LOCK_LAST) begin
                    state_d = ST_HOLD;
                    lcnt_d  = '0;
                end else begin
                    lcnt_d = lcnt_q + 1'b1;
                end
            end
        endcase
    end

    // Dividers only run while RUN persists, so a lock drop zeroes clk_en on the
    // same edge that pulls rst_out_n low.
    assign div_active = (state_q == ST_RUN) && locked_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_sync_q <= '0;
            mode_sync_q <= '0;
            req_sync_q  <= '0;
            req_s_d_q   <= 1'b0;
            mode_s_d_q  <= 1'b0;
            step_pls_q  <= 1'b0;
            state_q     <= ST_WAIT_LOCK;
            lcnt_q      <= '0;
            lost_q      <= 1'b0;
            rst_out_q   <= 1'b0;
        end else begin
            lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], bus.pll_locked};
            mode_sync_q <= {mode_sync_q[SYNC_STAGES-2:0], bus.step_mode};
            req_sync_q  <= {req_sync_q[SYNC_STAGES-2:0], bus.step_req};
            req_s_d_q   <= req_s;
            mode_s_d_q  <= mode_s;
            // Registered button edge: gives the SYNC_STAGES+2 step latency.
            step_pls_q  <= req_s & ~req_s_d_q;
            state_q     <= state_d;
            lcnt_q      <= lcnt_d;
            lost_q      <= lost_d;
            rst_out_q   <= (state_d == ST_RUN);
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clk_en_div #(
            .DIV_W(DIV_W)
        ) u_div (
            .clk        (clk),
            .rst_n      (rst_n),
            .load_i     (bus.cfg_we),
            .cfg_i      (bus.div_cfg[i*DIV_W +: DIV_W]),
            .active_i   (div_active),
            .hold_i     (mode_chg),
            .step_mode_i(mode_s),
            .step_i     (step_pls_q),
            .en_o       (clk_en_w[i])
        );
    end

    assign bus.rst_out_n = rst_out_q;
    assign bus.clk_en    = clk_en_w;
    assign bus.state     = state_q;
    assign bus.lock_lost = lost_q;
endmodule

// File: tb/tb_clk_rst_mgr.sv
// Directed bench for clk_rst_mgr: power-up, divide, step, lock loss, async reset, lock glitch.
// Latency: n/a.
// Backpressure: n/a.
module tb_clk_rst_mgr;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;

    clk_rst_mgr_if #(.NUM_CH(2), .DIV_W(8)) bus ();

    clk_rst_mgr dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        else n_pass++;
    endtask

    // Advance n rising edges, then settle 1ns past the last one.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [1:0] div_pat [8];
    logic [1:0] div_pat2[4];

    initial begin
        n_chk = 0;
        n_pass = 0;
        div_pat  = '{2'b01, 2'b01, 2'b01, 2'b11, 2'b01, 2'b01, 2'b01, 2'b11};
        div_pat2 = '{2'b01, 2'b11, 2'b01, 2'b11};
        rst_n = 1'b0;
        bus.pll_locked = 1'b0;
        bus.div_cfg    = '0;
        bus.cfg_we     = 1'b0;
        bus.step_mode  = 1'b0;
        bus.step_req   = 1'b0;

        // Reset values.
        cyc(3);
        chk("rst_rst_out_n", bus.rst_out_n, 0);
        chk("rst_clk_en", bus.clk_en, 0);
        chk("rst_state", bus.state, 0);
        chk("rst_lock_lost", bus.lock_lost, 0);

        // Power-up: lock to release in 26 edges, first enable at the next edge.
        rst_n = 1'b1;
        bus.pll_locked = 1'b1;
        for (int i = 1; i <= 27; i++) begin
            cyc(1);
            if (i == 17) chk("pu_state_wait", bus.state, 0);
            if (i == 18) chk("pu_state_hold", bus.state, 1);
            if (i == 25) chk("pu_rst_low_25", bus.rst_out_n, 0);
            if (i == 26) begin
                chk("pu_rst_high_26", bus.rst_out_n, 1);
                chk("pu_state_run", bus.state, 2);
                chk("pu_en_26", bus.clk_en, 0);
            end
            if (i == 27) chk("pu_en_27", bus.clk_en, 2'b11);
        end

        // Divide: ch0 ratio 0, ch1 ratio 3.
        bus.div_cfg = {8'd3, 8'd0};
        bus.cfg_we  = 1'b1;
        cyc(1);
        bus.cfg_we  = 1'b0;
        chk("div_load_cycle", bus.clk_en, 0);
        for (int i = 0; i < 8; i++) begin
            cyc(1);
            chk($sformatf("div_pat_%0d", i), bus.clk_en, div_pat[i]);
        end
        cyc(1);
        chk("div_mid", bus.clk_en, 2'b01);
        // Reprogram ch1 to ratio 1 mid-period.
        bus.div_cfg = {8'd1, 8'd0};
        bus.cfg_we  = 1'b1;
        cyc(1);
        bus.cfg_we  = 1'b0;
        chk("div_reload_cycle", bus.clk_en, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            chk($sformatf("div_pat2_%0d", i), bus.clk_en, div_pat2[i]);
        end

        // Step mode: three presses, pulse 4 edges after each, nothing while held.
        bus.step_mode = 1'b1;
        cyc(5);
        chk("step_idle", bus.clk_en, 0);
        for (int p = 0; p < 3; p++) begin
            bus.step_req = 1'b1;
            for (int e = 1; e <= 8; e++) begin
                cyc(1);
                chk($sformatf("step%0d_e%0d", p, e), bus.clk_en, (e == 4) ? 2'b11 : 2'b00);
            end
            bus.step_req = 1'b0;
            for (int e = 1; e <= 4; e++) begin
                cyc(1);
                chk($sformatf("step%0d_rel%0d", p, e), bus.clk_en, 0);
            end
        end
        bus.step_mode = 1'b0;
        cyc(4);
        chk("step_exit", bus.clk_en, 2'b01);

        // Lock loss in RUN.
        bus.pll_locked = 1'b0;
        cyc(2);
        chk("loss_rst_still_high", bus.rst_out_n, 1);
        chk("loss_state_still_run", bus.state, 2);
        cyc(1);
        chk("loss_rst_low", bus.rst_out_n, 0);
        chk("loss_en_zero", bus.clk_en, 0);
        chk("loss_lock_lost", bus.lock_lost, 1);
        chk("loss_state_wait", bus.state, 0);
        bus.pll_locked = 1'b1;
        cyc(20);
        chk("relock_state_hold", bus.state, 1);
        chk("relock_lost_sticky", bus.lock_lost, 1);
        chk("relock_rst_low", bus.rst_out_n, 0);

        // Async reset in HOLD: outputs reset before any clock edge.
        rst_n = 1'b0;
        #2;
        chk("arst_state", bus.state, 0);
        chk("arst_lock_lost", bus.lock_lost, 0);
        chk("arst_rst_out_n", bus.rst_out_n, 0);
        chk("arst_clk_en", bus.clk_en, 0);
        cyc(1);
        rst_n = 1'b1;

        // Restart with a 4-cycle lock glitch at count 10.
        cyc(12);
        bus.pll_locked = 1'b0;
        cyc(4);
        bus.pll_locked = 1'b1;
        for (int i = 1; i <= 26; i++) begin
            cyc(1);
            if (i == 17) chk("gl_state_wait", bus.state, 0);
            if (i == 25) chk("gl_rst_low_25", bus.rst_out_n, 0);
            if (i == 26) begin
                chk("gl_rst_high_26", bus.rst_out_n, 1);
                chk("gl_state_run", bus.state, 2);
                chk("gl_lock_lost", bus.lock_lost, 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
